// File: rtl/sva_resp_pkg.sv
// Shared types and width helpers for the capture-and-compare responder.
package sva_resp_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } state_e;

    // Bits needed to hold a FIFO occupancy of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sva_resp_fifo.sv
// Pending-capture FIFO: power-of-two depth, wrapping pointers, same-cycle push+pop even when full.
module sva_resp_fifo
    import sva_resp_pkg::*;
#(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [W-1:0]                  i_data,
    output logic [W-1:0]                  o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot this edge, so a full FIFO can still accept a push.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sva_capture_responder.sv
// Capture-and-compare responder: session FSM, two sample chains, length counter, capture queue.
module sva_capture_responder
    import sva_resp_pkg::*;
#(
    parameter int unsigned W       = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          f,
    input  logic [W-1:0]                  e,
    input  logic [W-1:0]                  a,
    input  logic                          c,
    input  logic                          tick1,
    input  logic                          tick2,
    output logic                          b,
    output logic [W-1:0]                  d,
    output logic                          busy,
    output logic [count_width(DEPTH)-1:0] pending,
    output logic                          overflow,
    output logic                          timeout
);

    localparam int unsigned   LW      = $clog2(MAX_LEN);
    localparam logic [LW-1:0] LenLast = LW'(MAX_LEN - 1);

    state_e        r_state;
    logic          r_f_q;
    logic [W-1:0]  r_v;
    logic          r_alive1;
    logic          r_alive2;
    logic [LW-1:0] r_len;
    logic          r_overflow;

    logic          w_active;
    logic          w_hit1;
    logic          w_hit2;
    logic          w_alive1_d;
    logic          w_alive2_d;
    logic          w_norm_end;
    logic          w_time_end;
    logic          w_end;
    logic          w_free;
    logic          w_pop;
    logic          w_push;
    logic          w_load_cap;
    logic          w_load;
    logic          w_drop;
    logic [W-1:0]  w_load_val;
    logic [W-1:0]  w_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;

    assign w_active   = (r_state == StActive);
    assign w_hit1     = w_active && tick1 && r_alive1;
    assign w_hit2     = w_active && tick2 && r_alive2;
    assign w_alive1_d = r_alive1 && !(w_hit1 && (a != r_v));
    assign w_alive2_d = r_alive2 && !(w_hit2 && !c);
    assign w_norm_end = w_active && !w_alive1_d && !w_alive2_d;
    // A normal end wins over a coincident timeout.
    assign w_time_end = w_active && (r_len == LenLast) && !w_norm_end;
    assign w_end      = w_norm_end || w_time_end;

    // The queue head is older than a same-cycle capture, so it is served first.
    assign w_free     = w_end || !w_active;
    assign w_pop      = w_free && !w_fifo_empty;
    assign w_load_cap = r_f_q && w_free && w_fifo_empty;
    assign w_push     = r_f_q && !w_load_cap;
    assign w_drop     = w_push && w_fifo_full && !w_pop;
    assign w_load     = w_pop || w_load_cap;
    assign w_load_val = w_pop ? w_head : e;

    sva_resp_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (e),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (pending)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_f_q      <= 1'b0;
            r_v        <= '0;
            r_alive1   <= 1'b0;
            r_alive2   <= 1'b0;
            r_len      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_f_q <= f;
            if (w_drop) r_overflow <= 1'b1;
            if (w_load) begin
                r_state  <= StActive;
                r_v      <= w_load_val;
                r_alive1 <= 1'b1;
                r_alive2 <= 1'b1;
                r_len    <= '0;
            end else if (w_end) begin
                r_state  <= StIdle;
                r_alive1 <= 1'b0;
                r_alive2 <= 1'b0;
            end else if (w_active) begin
                r_alive1 <= w_alive1_d;
                r_alive2 <= w_alive2_d;
                if (r_len != LenLast) r_len <= r_len + 1'b1;
            end
        end
    end

    assign b        = w_hit1 && (a == r_v);
    assign d        = (w_active && r_alive2) ? r_v : '0;
    assign busy     = w_active;
    assign overflow = r_overflow;
    assign timeout  = w_time_end;

endmodule

// File: tb/tb_sva_capture_responder.sv
// Directed bench for sva_capture_responder: per-cycle vector table plus queue/reset sequences.
module tb_sva_capture_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       f;
    logic [3:0] e;
    logic [3:0] a;
    logic       c;
    logic       tick1;
    logic       tick2;
    logic       b;
    logic [3:0] d;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;
    logic       timeout;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst_n;
        logic       f;
        logic [3:0] e;
        logic       t1;
        logic [3:0] a;
        logic       t2;
        logic       c;
        logic       eb;
        logic [3:0] ed;
        logic       ebusy;
        logic [2:0] epend;
        logic       eovf;
        logic       eto;
    } vec_t;

    vec_t vecs[$];

    sva_capture_responder #(
        .W       (4),
        .DEPTH   (4),
        .MAX_LEN (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f        (f),
        .e        (e),
        .a        (a),
        .c        (c),
        .tick1    (tick1),
        .tick2    (tick2),
        .b        (b),
        .d        (d),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic drive(input logic rv, input logic fv, input logic [3:0] ev, input logic t1v,
                         input logic [3:0] av, input logic t2v, input logic cv);
        rst_n = rv; f = fv; e = ev; tick1 = t1v; a = av; tick2 = t2v; c = cv;
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at the following negedge.
    task automatic settle();
        #4;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic rv, input logic fv, input logic [3:0] ev,
                                input logic t1v, input logic [3:0] av, input logic t2v,
                                input logic cv, input logic eb, input logic [3:0] ed,
                                input logic ebusy, input logic [2:0] epend, input logic eovf,
                                input logic eto);
        vec_t t;
        t.rst_n = rv; t.f = fv; t.e = ev; t.t1 = t1v; t.a = av; t.t2 = t2v; t.c = cv;
        t.eb = eb; t.ed = ed; t.ebusy = ebusy; t.epend = epend; t.eovf = eovf; t.eto = eto;
        vecs.push_back(t);
    endfunction

    initial begin
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        advance();
        advance();

        // Reset state
        add(0, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        // Chain 1: v=5, matches at 3..5, mismatch at 6, dead after; chain 2 ends it at 8
        add(1, 1, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        add(1, 0, 4'h5, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h5, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h5, 0, 0,  1, 4'h5, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h5, 0, 0,  1, 4'h5, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h5, 0, 0,  1, 4'h5, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h3, 0, 0,  0, 4'h5, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h5, 0, 0,  0, 4'h5, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 1, 0,  0, 4'h5, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        // Chain 2: v=A, c=1,1,0 at 3..5; chain 1 killed at 3
        add(1, 1, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        add(1, 0, 4'hA, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'hA, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h0, 1, 1,  0, 4'hA, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 1, 1,  0, 4'hA, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 1, 0,  0, 4'hA, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        // Timeout: no ticks, pulse in the 8th active cycle
        add(1, 1, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        add(1, 0, 4'h7, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h7, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h7, 1, 0, 0, 1);
        add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        // Both chains die on the last length cycle: normal end, no timeout
        add(1, 1, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        add(1, 0, 4'h3, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h3, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h0, 1, 0,  0, 4'h3, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].f, vecs[i].e, vecs[i].t1, vecs[i].a, vecs[i].t2,
                  vecs[i].c);
            settle();
            chk($sformatf("v%0d.b", i), b, vecs[i].eb);
            chk($sformatf("v%0d.d", i), d, vecs[i].ed);
            chk($sformatf("v%0d.busy", i), busy, vecs[i].ebusy);
            chk($sformatf("v%0d.pending", i), pending, vecs[i].epend);
            chk($sformatf("v%0d.overflow", i), overflow, vecs[i].eovf);
            chk($sformatf("v%0d.timeout", i), timeout, vecs[i].eto);
            advance();
        end

        // Overflow: v=1 session, five captures queued, fifth dropped, then drained in order
        drive(1, 1, 4'h0, 0, 4'h0, 0, 0); advance();
        drive(1, 0, 4'h1, 0, 4'h0, 0, 0); advance();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, (i == 0) ? 4'h0 : 4'(i + 1), 0, 4'h0, 0, 0);
            advance();
        end
        drive(1, 0, 4'h6, 0, 4'h0, 0, 0); settle();
        chk("ovf.pend_full", pending, 3'd4);
        chk("ovf.not_yet", overflow, 1'b0);
        advance();
        drive(1, 0, 4'h0, 0, 4'h0, 0, 0); settle();
        chk("ovf.pend_hold", pending, 3'd4);
        chk("ovf.sticky_set", overflow, 1'b1);
        chk("ovf.d_first", d, 4'h1);
        advance();
        settle();
        chk("ovf.timeout", timeout, 1'b1);
        advance();
        for (int k = 2; k <= 5; k++) begin
            drive(1, 0, 4'h0, 1, 4'h0, 1, 0); settle();
            chk($sformatf("ovf.order%0d.d", k), d, 32'(k));
            chk($sformatf("ovf.order%0d.pend", k), pending, 32'(5 - k));
            chk($sformatf("ovf.order%0d.b", k), b, 1'b0);
            advance();
        end
        drive(1, 0, 4'h0, 0, 4'h0, 0, 0); settle();
        chk("ovf.drained_busy", busy, 1'b0);
        chk("ovf.still_set", overflow, 1'b1);
        advance();

        // Full FIFO, session ends as a capture arrives: push+pop, no overflow
        drive(0, 0, 4'h0, 0, 4'h0, 0, 0); advance();
        drive(1, 0, 4'h0, 0, 4'h0, 0, 0); settle();
        chk("rst.ovf_clear", overflow, 1'b0);
        chk("rst.pend_clear", pending, 3'd0);
        advance();
        drive(1, 1, 4'h0, 0, 4'h0, 0, 0); advance();
        drive(1, 0, 4'h1, 0, 4'h0, 0, 0); advance();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, (i == 0) ? 4'h0 : 4'(i + 1), 0, 4'h0, 0, 0);
            advance();
        end
        drive(1, 0, 4'h6, 1, 4'h0, 1, 0); settle();
        chk("pp.pend_full", pending, 3'd4);
        advance();
        drive(1, 0, 4'h0, 1, 4'h0, 1, 0); settle();
        chk("pp.pend_kept", pending, 3'd4);
        chk("pp.no_ovf", overflow, 1'b0);
        chk("pp.head_d", d, 4'h2);
        chk("pp.busy", busy, 1'b1);
        advance();
        drive(1, 0, 4'h0, 1, 4'h0, 1, 0); settle();
        chk("pp.next_d", d, 4'h3);
        chk("pp.next_pend", pending, 3'd3);
        advance();

        // Reset mid-session with two captures pending
        drive(0, 0, 4'h0, 0, 4'h0, 0, 0); settle();
        chk("mid.pre_d", d, 4'h4);
        chk("mid.pre_pend", pending, 3'd2);
        advance();
        drive(1, 1, 4'h0, 0, 4'h0, 0, 0); settle();
        chk("mid.b", b, 1'b0);
        chk("mid.d", d, 4'h0);
        chk("mid.busy", busy, 1'b0);
        chk("mid.pend", pending, 3'd0);
        chk("mid.ovf", overflow, 1'b0);
        chk("mid.timeout", timeout, 1'b0);
        advance();
        drive(1, 0, 4'h9, 0, 4'h0, 0, 0); settle();
        chk("restart.busy_t1", busy, 1'b0);
        advance();
        drive(1, 0, 4'h0, 0, 4'h0, 0, 0); settle();
        chk("restart.busy_t2", busy, 1'b1);
        chk("restart.d", d, 4'h9);
        chk("restart.pend", pending, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
